award_dispatch: RTL and testbench
=================================

AWARD_DISPATCH -- requirements
Module: award_dispatch

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: the number of AWARD-state cycles to wait for an acknowledge before abandoning the award (legal range 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port win_valid  input  1  winner index offered by the auction stage.
REQ-005 SHALL have port win_idx  input  4  winning agent index, legal 0..9.
REQ-006 SHALL have port win_ready  output  1  dispatcher can accept a winner index.
REQ-007 SHALL have port award  output  10  one-hot award to agent 0..9.
REQ-008 SHALL have port award_ack  input  10  per-agent acknowledge.
REQ-009 SHALL have port busy  output  1  an award is outstanding.
REQ-010 SHALL have port err_p  output  1  one-cycle pulse: illegal index rejected.
REQ-011 SHALL have port timeout_p  output  1  one-cycle pulse: award abandoned.
REQ-012 SHALL have port stat_sel  input  4  statistics agent select (present only with AWARD_STATS_EN).
REQ-013 SHALL have port stat_cnt  output  8  win count of agent stat_sel (present only with AWARD_STATS_EN).

Function
REQ-014 SHALL implement a two-state FSM with states IDLE and AWARD.
REQ-015 SHALL drive win_ready = 1 exactly when the state is IDLE, decoded from state only, with no combinational path from any input.
REQ-016 SHALL define an accept as win_valid && win_ready at a rising edge.
REQ-017 SHALL, on an accept with win_idx <= 9: register the index, enter AWARD, clear the wait counter, and drive award one-hot at that index starting the next cycle (latency 1).
REQ-018 SHALL, on an accept with win_idx >= 10: stay in IDLE, leave award at zero, and pulse err_p for exactly one cycle in the next cycle.
REQ-019 SHALL, in AWARD, hold award and busy at 1 and ignore win_valid.
REQ-020 SHALL, in AWARD, complete the award when award_ack[registered idx] = 1: return to IDLE, with award = 0 in the next cycle.
REQ-021 SHALL ignore award_ack bits other than the registered index.
REQ-022 SHALL increment the wait counter each AWARD cycle without a valid ack.
REQ-023 SHALL, when the counter reaches TIMEOUT-1 with no valid ack in that cycle: return to IDLE, clear award, and pulse timeout_p for one cycle in the next cycle.
REQ-024 SHALL give ack priority over timeout when both occur in the same cycle: completion, no timeout_p.
REQ-025 SHALL sustain a minimum spacing of 2 cycles between consecutive accepts (accept, ack-in-first-AWARD-cycle, accept).
REQ-026 SHALL never drive award with more than one bit set.
REQ-027 SHALL tie busy to the AWARD state.

Reset
REQ-028 SHALL, while rst = 1, immediately force: state IDLE, award = 0, busy = 0, err_p = 0, timeout_p = 0, wait counter = 0, and statistics counters = 0.
REQ-029 SHALL, if reset is asserted during AWARD, abandon the award silently with no timeout_p, and accept a new winner on the first edge after rst deasserts.

Configuration
REQ-030 SHALL, with macro AWARD_STATS_EN defined, keep ten 8-bit win counters, each incrementing by 1 on completion of an award to that agent and saturating at 255.
REQ-031 SHALL, with AWARD_STATS_EN defined, drive stat_cnt combinationally with the selected counter, and drive 0 for stat_sel >= 10.
REQ-032 SHALL, without AWARD_STATS_EN, omit stat_sel, stat_cnt and all counter logic; all other behaviour is identical.

Verification
REQ-033 SHALL pass this scenario: accept idx 3, ack[3] in the 2nd AWARD cycle -> award = 10'b0000001000 for 2 cycles, then 0; win_ready high again next cycle.
REQ-034 SHALL pass this scenario: accept idx 12 -> err_p pulses once, award stays 0, win_ready stays 1.
REQ-035 SHALL pass this scenario: TIMEOUT = 4, accept idx 7, no ack -> award high 4 cycles, then timeout_p pulses 1 cycle; ack[6] asserted throughout is ignored.
REQ-036 SHALL pass this scenario: TIMEOUT = 4, ack[7] in the 4th AWARD cycle -> completion, no timeout_p.
REQ-037 SHALL pass this scenario: rst asserted mid-AWARD -> award = 0 immediately, no timeout_p; idx 0 accepted on the first post-reset edge.
REQ-038 SHALL pass this scenario: with AWARD_STATS_EN, 300 completed awards to agent 9 -> stat_cnt = 255 with stat_sel = 9, and 0 with stat_sel = 11.

Source files
------------

// File: rtl/award_dispatch_if.sv
// Winner/award bus between the auction stage and award_dispatch.
// win_valid/win_idx/win_ready: a winner transfers on any rising edge where win_valid && win_ready; win_ready never depends combinationally on win_valid.
interface award_dispatch_if;
  logic       win_valid;
  logic [3:0] win_idx;
  logic       win_ready;
  logic [9:0] award;
  logic [9:0] award_ack;
  logic       busy;
  logic       err_p;
  logic       timeout_p;

  modport master (
    output win_valid, win_idx, award_ack,
    input  win_ready, award, busy, err_p, timeout_p
  );

  modport slave (
    input  win_valid, win_idx, award_ack,
    output win_ready, award, busy, err_p, timeout_p
  );
endinterface

// File: rtl/award_dispatch.sv
// Award dispatcher: turns an accepted winner index into a one-hot award held until ack or TIMEOUT.
// Optional per-agent win statistics are built only when AWARD_STATS_EN is defined.
module award_dispatch #(
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  award_dispatch_if.slave   bus,
`ifdef AWARD_STATS_EN
  input  logic [3:0]        stat_sel,
  output logic [7:0]        stat_cnt,
`endif
  output logic              state_dbg
);

  typedef enum logic {IDLE = 1'b0, AWARD = 1'b1} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] wait_q, wait_d;
  logic       err_q, err_d;
  logic       to_q, to_d;
  logic [9:0] award_oh;
  logic       ack_hit;
  logic       complete;

  // Award is decoded from state, so reset clears it without waiting for a clock.
  assign award_oh = (state_q == AWARD) ? (10'd1 << idx_q) : 10'd0;
  assign ack_hit  = |(bus.award_ack & award_oh);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wait_d   = wait_q;
    err_d    = 1'b0;
    to_d     = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.win_valid) begin
          if (bus.win_idx <= 4'd9) begin
            state_d = AWARD;
            idx_d   = bus.win_idx;
            wait_d  = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      AWARD: begin
        // Ack wins over an expiring wait in the same cycle.
        if (ack_hit) begin
          state_d  = IDLE;
          complete = 1'b1;
        end else if (wait_q == TO_LAST) begin
          state_d = IDLE;
          to_d    = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.win_ready = (state_q == IDLE);
  assign bus.busy      = (state_q == AWARD);
  assign bus.award     = award_oh;
  assign bus.err_p     = err_q;
  assign bus.timeout_p = to_q;
  assign state_dbg     = (state_q == AWARD);

`ifdef AWARD_STATS_EN
  logic [7:0] stat_q [10];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 10; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < 10; i++) begin
        if (complete && idx_q == 4'(i) && stat_q[i] != 8'hFF)
          stat_q[i] <= stat_q[i] + 8'd1;
      end
    end
  end

  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < 10; i++) begin
      if (stat_sel == 4'(i)) stat_cnt = stat_q[i];
    end
  end
`else
  logic unused_complete;
  assign unused_complete = complete;
`endif

endmodule

// File: tb/tb_award_dispatch.sv
// Self-checking bench for award_dispatch (TIMEOUT = 4): vector table, hand sequences, random transactions.
// Statistics checks are compiled in when AWARD_STATS_EN is defined.
module tb_award_dispatch;
  localparam int TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] stat_sel;
  logic [7:0] stat_cnt;
  logic       state_dbg;

  always #5 clk = ~clk;

  award_dispatch_if bus ();

  award_dispatch #(.TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
`ifdef AWARD_STATS_EN
    .stat_sel (stat_sel),
    .stat_cnt (stat_cnt),
`endif
    .state_dbg(state_dbg)
  );

`ifndef AWARD_STATS_EN
  assign stat_cnt = '0;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_cnt [10];
  logic [13:0] exp_q [$];

  typedef struct {
    logic [3:0] idx;
    int         ack_at;
    logic [9:0] noise;
    int         len;
    logic       err;
    logic       to;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] pack(input logic [9:0] a, input logic e, input logic t,
                                       input logic b, input logic r);
    return {a, e, t, b, r};
  endfunction

  function automatic logic [13:0] obs();
    return {bus.award, bus.err_p, bus.timeout_p, bus.busy, bus.win_ready};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outcome of one offered winner from the rules: illegal index errors out; otherwise the award
  // lasts until the ack cycle if it falls within TIMEOUT cycles, else TIMEOUT cycles then times out.
  task automatic ref_outcome(input logic [3:0] idx, input int ack_at,
                             output int len, output logic err, output logic to);
    logic completed;
    err       = (idx > 4'd9);
    completed = (ack_at >= 1) && (ack_at <= TIMEOUT);
    len       = err ? 0 : (completed ? ack_at : TIMEOUT);
    to        = !err && !completed;
  endtask

  task automatic count_win(input int agent);
    if (exp_cnt[agent] < 255) exp_cnt[agent]++;
  endtask

  task automatic apply(input logic [3:0] idx, input int ack_at, input logic [9:0] noise,
                       input int exp_len, input logic exp_err, input logic exp_to,
                       input string name);
    logic [9:0]  oh;
    logic [13:0] e;
    int          c;
    oh = (idx <= 4'd9) ? (10'd1 << idx) : 10'd0;
    exp_q.delete();
    if (exp_err) begin
      exp_q.push_back(pack(10'd0, 1'b1, 1'b0, 1'b0, 1'b1));
    end else begin
      for (int k = 1; k <= exp_len; k++) exp_q.push_back(pack(oh, 1'b0, 1'b0, 1'b1, 1'b0));
      exp_q.push_back(pack(10'd0, 1'b0, exp_to, 1'b0, 1'b1));
      if (!exp_to) count_win(int'(idx));
    end
    exp_q.push_back(pack(10'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    bus.win_valid = 1'b1;
    bus.win_idx   = idx;
    bus.award_ack = noise & ~oh;
    tick();
    c = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(name, 32'(obs()), 32'(e));
      chk({name, "_state"}, 32'(state_dbg), 32'(e[1]));
      bus.award_ack = (noise & ~oh) | ((c == ack_at) ? oh : 10'd0);
      // Offers made while an award is outstanding must be ignored.
      bus.win_valid = e[1] ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.win_idx   = 4'($urandom_range(0, 15));
      tick();
      c++;
    end
    bus.win_valid = 1'b0;
    bus.award_ack = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          len;
    logic        err, to;
    logic [3:0]  ridx;
    int          rack;

    rst           = 1'b1;
    bus.win_valid = 1'b0;
    bus.win_idx   = '0;
    bus.award_ack = '0;
    stat_sel      = '0;
    for (int i = 0; i < 10; i++) exp_cnt[i] = 0;
    #1;
    chk("reset_outputs", 32'(obs()), 32'(pack(10'd0, 1'b0, 1'b0, 1'b0, 1'b1)));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    vecs[0] = '{4'd3,  2, 10'h000, 2, 1'b0, 1'b0};
    vecs[1] = '{4'd12, 0, 10'h000, 0, 1'b1, 1'b0};
    vecs[2] = '{4'd7,  0, 10'h040, 4, 1'b0, 1'b1};
    vecs[3] = '{4'd7,  4, 10'h000, 4, 1'b0, 1'b0};
    vecs[4] = '{4'd0,  1, 10'h3FE, 1, 1'b0, 1'b0};
    vecs[5] = '{4'd9,  3, 10'h1FF, 3, 1'b0, 1'b0};
    vecs[6] = '{4'd10, 0, 10'h000, 0, 1'b1, 1'b0};
    vecs[7] = '{4'd15, 1, 10'h3FF, 0, 1'b1, 1'b0};
    vecs[8] = '{4'd5,  5, 10'h000, 4, 1'b0, 1'b1};
    vecs[9] = '{4'd1,  3, 10'h2AA, 3, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++)
      apply(vecs[i].idx, vecs[i].ack_at, vecs[i].noise, vecs[i].len, vecs[i].err, vecs[i].to,
            $sformatf("vec%0d", i));

    // Back-to-back: accept, ack in first AWARD cycle, accept again two edges later.
    bus.win_valid = 1'b1;
    bus.win_idx   = 4'd2;
    tick();
    chk("b2b_first_award", 32'(obs()), 32'(pack(10'h004, 1'b0, 1'b0, 1'b1, 1'b0)));
    bus.award_ack = 10'h004;
    bus.win_idx   = 4'd5;
    tick();
    chk("b2b_idle_gap", 32'(obs()), 32'(pack(10'h000, 1'b0, 1'b0, 1'b0, 1'b1)));
    bus.award_ack = 10'h000;
    tick();
    chk("b2b_second_award", 32'(obs()), 32'(pack(10'h020, 1'b0, 1'b0, 1'b1, 1'b0)));
    bus.win_valid = 1'b0;
    bus.award_ack = 10'h020;
    tick();
    chk("b2b_done", 32'(obs()), 32'(pack(10'h000, 1'b0, 1'b0, 1'b0, 1'b1)));
    bus.award_ack = '0;
    count_win(2);
    count_win(5);

    // Reset in the middle of an award, then accept on the first edge after release.
    bus.win_valid = 1'b1;
    bus.win_idx   = 4'd4;
    tick();
    bus.win_valid = 1'b0;
    tick();
    chk("rst_mid_before", 32'(obs()), 32'(pack(10'h010, 1'b0, 1'b0, 1'b1, 1'b0)));
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_async", 32'(obs()), 32'(pack(10'h000, 1'b0, 1'b0, 1'b0, 1'b1)));
    for (int i = 0; i < 10; i++) exp_cnt[i] = 0;
    @(negedge clk);
    bus.win_valid = 1'b1;
    bus.win_idx   = 4'd0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rst_first_accept", 32'(obs()), 32'(pack(10'h001, 1'b0, 1'b0, 1'b1, 1'b0)));
    bus.win_valid = 1'b0;
    bus.award_ack = 10'h001;
    tick();
    chk("rst_after_ack", 32'(obs()), 32'(pack(10'h000, 1'b0, 1'b0, 1'b0, 1'b1)));
    bus.award_ack = '0;
    count_win(0);

    // Random transactions against the outcome model.
    for (int n = 0; n < 60; n++) begin
      ridx = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      rack = $urandom_range(0, TIMEOUT + 1);
      ref_outcome(ridx, rack, len, err, to);
      apply(ridx, rack, 10'($urandom_range(0, 1023)), len, err, to, $sformatf("rand%0d", n));
    end

`ifdef AWARD_STATS_EN
    for (int n = 0; n < 300; n++) apply(4'd9, 1, 10'($urandom_range(0, 1023)), 1, 1'b0, 1'b0, "stats_fill");
    for (int s = 0; s < 12; s++) begin
      stat_sel = 4'(s);
      #1;
      chk($sformatf("stat_cnt_sel%0d", s), 32'(stat_cnt), (s < 10) ? 32'(exp_cnt[s]) : 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
